// File: rtl/data_pack_pkg.sv
// data_pack_pkg: shared definitions for the pixel-to-word packer.
//   - FSM state encoding (IDLE / ACTIVE / FLUSH, 2 bits)
//   - pack_div_f(): pixels per packed word
//   - pack_cfg_ok(): legality of a PIXEL_BIT / PACK_BIT pairing, checked at elaboration
package data_pack_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_FLUSH  = 2'd2;

   function automatic int unsigned pack_div_f(input int unsigned pixel_bit,
                                              input int unsigned pack_bit);
      if (pixel_bit == 0) return 0;
      return pack_bit / pixel_bit;
   endfunction

   // Word must hold a whole number of pixels and the lane counter is 4 bits wide.
   function automatic bit pack_cfg_ok(input int unsigned pixel_bit,
                                      input int unsigned pack_bit);
      int unsigned div;
      if (pixel_bit == 0) return 1'b0;
      div = pack_bit / pixel_bit;
      return ((pack_bit % pixel_bit) == 0) && (div >= 2) && (div <= 16);
   endfunction

endpackage

// File: rtl/shift_reg.sv
// shift_reg: TAPE-stage delay line of D_WIDTH-bit words with enable and
// active-high asynchronous clear.
//   i_clk  : clock
//   i_arst : asynchronous clear, active high
//   i_en   : shift enable
//   i_d    : input word
//   o_d    : input word delayed TAPE enabled cycles
module shift_reg #(
   parameter int unsigned D_WIDTH = 1,
   parameter int unsigned TAPE    = 1
) (
   input  logic               i_clk,
   input  logic               i_arst,
   input  logic               i_en,
   input  logic [D_WIDTH-1:0] i_d,
   output logic [D_WIDTH-1:0] o_d
);

   logic [D_WIDTH-1:0] stage_q [TAPE];
   logic [D_WIDTH-1:0] stage_d [TAPE];

   always_comb begin
      for (int i = 0; i < TAPE; i++) begin
         stage_d[i] = stage_q[i];
      end
      if (i_en) begin
         stage_d[0] = i_d;
         for (int i = 1; i < TAPE; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         for (int i = 0; i < TAPE; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < TAPE; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign o_d = stage_q[TAPE-1];

endmodule

// File: rtl/data_pack.sv
// data_pack: packs PACK_DIV = PACK_BIT/PIXEL_BIT pixels into one PACK_BIT word.
// The first pixel of a word lands in the LSBs; a partial last word of a line is
// zero-padded and flushed one cycle after in_de falls.
//   in_pclk, in_rstn   : clock, asynchronous active-low reset
//   in_x / in_y        : pixel coordinates (in_x only checked against arrival order)
//   in_valid / in_de   : pixel qualifier / data enable; accept = in_valid && in_de
//   in_hs / in_vs      : syncs, passed through with a 2-cycle delay
//   in_data            : pixel
//   out_valid/out_data : 1-cycle pulse with a packed word, out_x = word index in line
//   out_y              : in_y of the first pixel of the line
//   out_de/hs/vs       : inputs delayed 2 cycles
//   out_x_total        : last word index of the most recently completed line
//   out_err            : pulse when in_x differs from the expected pixel index
module data_pack
   import data_pack_pkg::*;
#(
   parameter int unsigned PIXEL_BIT  = 32,
   parameter int unsigned PACK_BIT   = 64,
   parameter int unsigned FIFO_WIDTH = 10
) (
   input  logic                  in_pclk,
   input  logic                  in_rstn,
   input  logic [FIFO_WIDTH-1:0] in_x,
   input  logic [FIFO_WIDTH-1:0] in_y,
   input  logic                  in_valid,
   input  logic                  in_de,
   input  logic                  in_hs,
   input  logic                  in_vs,
   input  logic [PIXEL_BIT-1:0]  in_data,
   output logic [FIFO_WIDTH-1:0] out_x,
   output logic [FIFO_WIDTH-1:0] out_y,
   output logic                  out_valid,
   output logic                  out_de,
   output logic                  out_hs,
   output logic                  out_vs,
   output logic [PACK_BIT-1:0]   out_data,
   output logic [FIFO_WIDTH-1:0] out_x_total,
   output logic                  out_err
);

   localparam int unsigned           PACK_DIV  = pack_div_f(PIXEL_BIT, PACK_BIT);
   localparam logic [3:0]            LAST_LANE = 4'(PACK_DIV - 1);
   localparam logic [FIFO_WIDTH-1:0] XY_ONE    = FIFO_WIDTH'(1);

   if (!pack_cfg_ok(PIXEL_BIT, PACK_BIT)) begin : g_cfg_bad
      $error("data_pack: PACK_BIT must be PIXEL_BIT times 2..16");
   end

   logic [1:0]            state_q, state_d;
   logic                  de_prev_q, de_prev_d;
   logic [3:0]            pcnt_q, pcnt_d;
   logic [FIFO_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [FIFO_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
   logic                  got_pix_q, got_pix_d;
   logic [PACK_BIT-1:0]   acc_q, acc_d;
   logic [PACK_BIT-1:0]   acc_wr;
   logic                  out_valid_q, out_valid_d;
   logic [PACK_BIT-1:0]   out_data_q, out_data_d;
   logic [FIFO_WIDTH-1:0] out_x_q, out_x_d;
   logic [FIFO_WIDTH-1:0] out_y_q, out_y_d;
   logic [FIFO_WIDTH-1:0] out_x_total_q, out_x_total_d;
   logic                  out_err_q, out_err_d;

   logic de_rise, de_fall, accept;

   assign de_rise = in_de && !de_prev_q;
   assign de_fall = !in_de && de_prev_q;
   // In IDLE only the rising edge opens a line; FLUSH may already take the
   // first pixel of the next line.
   assign accept  = in_valid && in_de && ((state_q != ST_IDLE) || de_rise);

   always_comb begin
      state_d       = state_q;
      de_prev_d     = in_de;
      pcnt_d        = pcnt_q;
      word_cnt_d    = word_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      got_pix_d     = got_pix_q;
      acc_d         = acc_q;
      out_valid_d   = 1'b0;
      out_data_d    = out_data_q;
      out_x_d       = out_x_q;
      out_y_d       = out_y_q;
      out_x_total_d = out_x_total_q;
      out_err_d     = 1'b0;

      acc_wr = acc_q;
      for (int unsigned i = 0; i < PACK_DIV; i++) begin
         if (pcnt_q == 4'(i)) begin
            acc_wr[i*PIXEL_BIT +: PIXEL_BIT] = in_data;
         end
      end

      if (accept) begin
         out_err_d = (in_x != pix_cnt_q);
         // Resync to the reported index so one skipped pixel yields one error.
         pix_cnt_d = in_x + XY_ONE;
         if (!got_pix_q) begin
            out_y_d   = in_y;
            got_pix_d = 1'b1;
         end
         if (pcnt_q == LAST_LANE) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_wr;
            out_x_d     = word_cnt_q;
            word_cnt_d  = word_cnt_q + XY_ONE;
            pcnt_d      = '0;
            acc_d       = '0;
         end else begin
            pcnt_d = pcnt_q + 4'd1;
            acc_d  = acc_wr;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (de_rise) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (de_fall) begin
               if (pcnt_q != 4'd0) begin
                  // Partial word: emit now, FLUSH is the cycle it is presented.
                  state_d       = ST_FLUSH;
                  out_valid_d   = 1'b1;
                  out_data_d    = acc_q;
                  out_x_d       = word_cnt_q;
                  out_x_total_d = word_cnt_q;
               end else begin
                  state_d = ST_IDLE;
                  if (word_cnt_q != '0) out_x_total_d = word_cnt_q - XY_ONE;
               end
               pcnt_d     = '0;
               word_cnt_d = '0;
               pix_cnt_d  = '0;
               got_pix_d  = 1'b0;
               acc_d      = '0;
            end
         end
         ST_FLUSH: begin
            state_d = in_de ? ST_ACTIVE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_pclk or negedge in_rstn) begin
      if (!in_rstn) begin
         state_q       <= ST_IDLE;
         de_prev_q     <= 1'b0;
         pcnt_q        <= '0;
         word_cnt_q    <= '0;
         pix_cnt_q     <= '0;
         got_pix_q     <= 1'b0;
         acc_q         <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_x_q       <= '0;
         out_y_q       <= '0;
         out_x_total_q <= '0;
         out_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         de_prev_q     <= de_prev_d;
         pcnt_q        <= pcnt_d;
         word_cnt_q    <= word_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         got_pix_q     <= got_pix_d;
         acc_q         <= acc_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_x_q       <= out_x_d;
         out_y_q       <= out_y_d;
         out_x_total_q <= out_x_total_d;
         out_err_q     <= out_err_d;
      end
   end

   logic       sync_arst;
   logic [2:0] sync_dly;

   assign sync_arst = ~in_rstn;

   shift_reg #(
      .D_WIDTH (3),
      .TAPE    (2)
   ) u_sync_dly (
      .i_clk  (in_pclk),
      .i_arst (sync_arst),
      .i_en   (1'b1),
      .i_d    ({in_vs, in_hs, in_de}),
      .o_d    (sync_dly)
   );

   assign out_de      = sync_dly[0];
   assign out_hs      = sync_dly[1];
   assign out_vs      = sync_dly[2];
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_x       = out_x_q;
   assign out_y       = out_y_q;
   assign out_x_total = out_x_total_q;
   assign out_err     = out_err_q;

endmodule
